i2c_seq_loader: RTL and testbench



---
 rtl/i2c_seq_pkg.sv | 6 +
 rtl/i2c_seq_arb.sv | 26 ++
 rtl/i2c_seq_loader.sv | 159 +++++++++++++++
 tb/tb_i2c_seq_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared FSM state encoding and register-table entry field widths.
package i2c_seq_pkg;
    localparam int DEV_W  = 8;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_ADV} state_t;
endpackage

// File: rtl/i2c_seq_arb.sv
// i2c_seq_arb: sticky pending-request register with a lowest-index-first priority encoder.
module i2c_seq_arb #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          take_i,
    output logic          valid_o,
    output logic [SW-1:0] sel_o
);
    logic [N-1:0] pending_q, pending_d;
    always_comb begin
        sel_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending_q[i]) sel_o = SW'(i);
    end
    assign valid_o = |pending_q;
    // New pulses are OR-ed after the clear so a same-cycle re-request stays queued
    assign pending_d = (pending_q & ~(take_i ? (N'(1) << sel_o) : N'(0))) | req_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end
endmodule

// File: rtl/i2c_seq_loader.sv
// i2c_seq_loader: walks register-table ranges per requester and issues I2C register writes with NACK retry.
module i2c_seq_loader
    import i2c_seq_pkg::*;
#(
    parameter  int LUT_DEPTH = 64,
    parameter  int REG_AW    = 8,
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_RETRY = 3,
    localparam int IDX_W     = $clog2(LUT_DEPTH),
    localparam int SW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*IDX_W-1:0]     Req_start,
    input  logic [NUM_REQ*(IDX_W+1)-1:0] Req_len,
    output logic                         Busy,
    output logic                         Done,
    output logic [SW-1:0]                Done_id,
    output logic                         Err,
    output logic [IDX_W-1:0]             Err_idx,
    input  logic                         Err_clr,
    output logic [IDX_W-1:0]             Tbl_idx,
    input  logic [DEV_W-1:0]             Tbl_dev,
    input  logic [REG_AW-1:0]            Tbl_reg,
    input  logic [DATA_W-1:0]            Tbl_data,
    output logic                         Wrreg_req,
    output logic [DEV_W-1:0]             Dev_id,
    output logic [15:0]                  Reg_addr,
    output logic [DATA_W-1:0]            Wr_data,
    output logic                         Addr_mode,
    input  logic                         RW_Done,
    input  logic                         Ack
);
    state_t              state_q, state_d;
    logic                ph_q, ph_d;
    logic [IDX_W-1:0]    idx_q, idx_d, err_idx_q, err_idx_d;
    logic [IDX_W:0]      len_q, len_d;
    logic [SW-1:0]       src_q, src_d, sel;
    logic [RW-1:0]       retry_q, retry_d;
    logic                done_q, done_d, err_q, err_d, take, valid;
    logic [DEV_W-1:0]    dev_q, dev_d;
    logic [REG_AW-1:0]   reg_q, reg_d;
    logic [DATA_W-1:0]   data_q, data_d;

    i2c_seq_arb #(.N(NUM_REQ), .SW(SW)) u_arb (
        .clk_i(Clk), .rst_i(Rst), .req_i(Req), .take_i(take), .valid_o(valid), .sel_o(sel)
    );

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        idx_d     = idx_q;
        len_d     = len_q;
        src_d     = src_q;
        retry_d   = retry_q;
        done_d    = 1'b0;
        err_d     = Err_clr ? 1'b0 : err_q;
        err_idx_d = err_idx_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        data_d    = data_q;
        take      = 1'b0;
        case (state_q)
            // Holding off while Done is high guarantees an idle cycle between runs
            S_IDLE: if (valid && !done_q) begin
                take    = 1'b1;
                src_d   = sel;
                idx_d   = Req_start[IDX_W*sel +: IDX_W];
                len_d   = Req_len[(IDX_W+1)*sel +: IDX_W+1];
                ph_d    = 1'b0;
                state_d = S_FETCH;
            end
            // Phase 0 presents the index, phase 1 captures the registered table output
            S_FETCH: if (len_q == '0) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else if (!ph_q) begin
                ph_d = 1'b1;
            end else begin
                ph_d    = 1'b0;
                dev_d   = Tbl_dev;
                reg_d   = Tbl_reg;
                data_d  = Tbl_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: if (RW_Done) begin
                if (!Ack) begin
                    retry_d = '0;
                    state_d = S_ADV;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    retry_d   = '0;
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ADV: begin
                len_d = len_q - 1'b1;
                if (len_q == 1 || idx_q == IDX_W'(LUT_DEPTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            ph_q      <= 1'b0;
            idx_q     <= '0;
            len_q     <= '0;
            src_q     <= '0;
            retry_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            dev_q     <= '0;
            reg_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            src_q     <= src_d;
            retry_q   <= retry_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
        end
    end

    assign Busy      = state_q != S_IDLE;
    assign Done      = done_q;
    assign Done_id   = src_q;
    assign Err       = err_q;
    assign Err_idx   = err_idx_q;
    assign Tbl_idx   = idx_q;
    assign Wrreg_req = state_q == S_ISSUE;
    assign Dev_id    = dev_q;
    assign Reg_addr  = 16'(reg_q);
    assign Wr_data   = data_q;
    assign Addr_mode = (REG_AW == 16);
endmodule

// File: tb/tb_i2c_seq_loader.sv
// tb_i2c_seq_loader: directed scenario tests with a registered table model and an I2C responder.
module tb_i2c_seq_loader;
    localparam int NR = 4;
    localparam int IW = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req = '0;
    logic [NR*IW-1:0]   req_start = '0;
    logic [NR*(IW+1)-1:0] req_len = '0;
    logic               busy, done, err, err_clr = 1'b0;
    logic [1:0]         done_id;
    logic [IW-1:0]      err_idx, tbl_idx;
    logic [7:0]         tbl_dev, tbl_data, tbl_reg, dev_id, wr_data;
    logic [15:0]        reg_addr;
    logic               wrreg_req, addr_mode;
    logic               rw_done = 1'b0, ack = 1'b0;

    int nerr = 0;
    int nchk = 0;
    int nack_idx = -1;
    int nack_times = 0;
    int log_idx[$];
    logic [7:0]  log_dev[$];
    logic [7:0]  log_data[$];
    logic [15:0] log_reg[$];
    int done_ids[$];
    int done_with_busy = 0;

    always #5 clk = ~clk;

    i2c_seq_loader dut (
        .Clk(clk), .Rst(rst), .Req(req), .Req_start(req_start), .Req_len(req_len),
        .Busy(busy), .Done(done), .Done_id(done_id), .Err(err), .Err_idx(err_idx),
        .Err_clr(err_clr), .Tbl_idx(tbl_idx), .Tbl_dev(tbl_dev), .Tbl_reg(tbl_reg),
        .Tbl_data(tbl_data), .Wrreg_req(wrreg_req), .Dev_id(dev_id), .Reg_addr(reg_addr),
        .Wr_data(wr_data), .Addr_mode(addr_mode), .RW_Done(rw_done), .Ack(ack)
    );

    function automatic logic [7:0] tdev(input int i);  return 8'h80 | 8'(i);     endfunction
    function automatic logic [7:0] treg(input int i);  return 8'(i * 3);         endfunction
    function automatic logic [7:0] tdata(input int i); return ~8'(i);            endfunction

    always @(posedge clk) begin
        tbl_dev  <= tdev(int'(tbl_idx));
        tbl_reg  <= treg(int'(tbl_idx));
        tbl_data <= tdata(int'(tbl_idx));
    end

    // Completes each write three cycles later; NACKs the first nack_times attempts at nack_idx
    initial begin : responder
        int cur, prev, rep;
        prev = -1;
        rep = 0;
        forever begin
            @(negedge clk);
            while (wrreg_req && !rst) begin
                cur = int'(tbl_idx);
                rep = (cur == prev) ? rep + 1 : 0;
                prev = cur;
                log_idx.push_back(cur);
                log_dev.push_back(dev_id);
                log_reg.push_back(reg_addr);
                log_data.push_back(wr_data);
                repeat (2) @(negedge clk);
                ack = (cur == nack_idx) && (rep < nack_times);
                rw_done = 1'b1;
                @(negedge clk);
                rw_done = 1'b0;
                ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_ids.push_back(int'(done_id));
            if (busy) done_with_busy++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int s, input int st, input int ln);
        req_start[s*IW +: IW] = IW'(st);
        req_len[s*(IW+1) +: IW+1] = (IW+1)'(ln);
        req[s] = 1'b1;
        tick();
        req[s] = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        int t;
        t = 0;
        while (done_ids.size() < target && t < 400) begin
            tick();
            t++;
        end
        nchk++;
        if (done_ids.size() < target) begin
            nerr++;
            $display("FAIL %s done timeout: got %0d dones, need %0d", nm, done_ids.size(), target);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        nchk++; if ({busy, done, err, wrreg_req} !== 4'b0) begin nerr++; $display("FAIL reset_flags got %b want 0000", {busy, done, err, wrreg_req}); end
        nchk++; if (tbl_idx !== '0) begin nerr++; $display("FAIL reset_tbl_idx got %0d want 0", tbl_idx); end
        nchk++; if (err_idx !== '0) begin nerr++; $display("FAIL reset_err_idx got %0d want 0", err_idx); end
        nchk++; if ({dev_id, reg_addr, wr_data} !== 32'h0) begin nerr++; $display("FAIL reset_bus got %h want 0", {dev_id, reg_addr, wr_data}); end
        nchk++; if (addr_mode !== 1'b0) begin nerr++; $display("FAIL addr_mode got %b want 0", addr_mode); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int b, d;
        b = log_idx.size();
        d = done_ids.size();
        send(0, 0, 5);
        wait_done(d + 1, "single");
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy got %b want 0", busy); end
        nchk++; if (log_idx.size() - b !== 5) begin nerr++; $display("FAIL single_count got %0d want 5", log_idx.size() - b); end
        if (log_idx.size() - b == 5)
            for (int i = 0; i < 5; i++) begin
                nchk++;
                if (log_idx[b+i] !== i || log_dev[b+i] !== tdev(i) || log_reg[b+i] !== 16'(treg(i)) || log_data[b+i] !== tdata(i)) begin
                    nerr++;
                    $display("FAIL single_entry%0d got idx=%0d dev=%h reg=%h data=%h want idx=%0d dev=%h reg=%h data=%h",
                             i, log_idx[b+i], log_dev[b+i], log_reg[b+i], log_data[b+i], i, tdev(i), 16'(treg(i)), tdata(i));
                end
            end
        nchk++; if (done_ids.size() > d && done_ids[d] !== 0) begin nerr++; $display("FAIL single_id got %0d want 0", done_ids[d]); end
        nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL single_err got %b want 0", err); end
    endtask

    task automatic test_arbitration();
        int b, d;
        int exp[5] = '{20, 21, 10, 11, 12};
        b = log_idx.size();
        d = done_ids.size();
        req_start[2*IW +: IW] = 6'd10;
        req_len[2*(IW+1) +: IW+1] = 7'd3;
        req_start[1*IW +: IW] = 6'd20;
        req_len[1*(IW+1) +: IW+1] = 7'd2;
        req = 4'b0110;
        tick();
        req = '0;
        wait_done(d + 2, "arb");
        nchk++; if (log_idx.size() - b !== 5) begin nerr++; $display("FAIL arb_count got %0d want 5", log_idx.size() - b); end
        if (log_idx.size() - b == 5)
            for (int i = 0; i < 5; i++) begin
                nchk++;
                if (log_idx[b+i] !== exp[i]) begin nerr++; $display("FAIL arb_order%0d got %0d want %0d", i, log_idx[b+i], exp[i]); end
            end
        if (done_ids.size() >= d + 2) begin
            nchk++; if (done_ids[d] !== 1 || done_ids[d+1] !== 2) begin nerr++; $display("FAIL arb_ids got %0d,%0d want 1,2", done_ids[d], done_ids[d+1]); end
        end
    endtask

    task automatic test_nack_persist();
        int b, d;
        int exp[7] = '{0, 1, 2, 3, 3, 3, 3};
        b = log_idx.size();
        d = done_ids.size();
        nack_idx = 3;
        nack_times = 1000;
        err_clr = 1'b1;
        send(0, 0, 6);
        wait_done(d + 1, "nack_persist");
        nchk++; if (err !== 1'b1) begin nerr++; $display("FAIL abort_err got %b want 1", err); end
        nchk++; if (err_idx !== 6'd3) begin nerr++; $display("FAIL abort_err_idx got %0d want 3", err_idx); end
        nchk++; if (log_idx.size() - b !== 7) begin nerr++; $display("FAIL abort_count got %0d want 7", log_idx.size() - b); end
        if (log_idx.size() - b == 7)
            for (int i = 0; i < 7; i++) begin
                nchk++;
                if (log_idx[b+i] !== exp[i]) begin nerr++; $display("FAIL abort_seq%0d got %0d want %0d", i, log_idx[b+i], exp[i]); end
            end
        tick();
        nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL err_clr got %b want 0", err); end
        err_clr = 1'b0;
        nack_idx = -1;
        repeat (5) tick();
        nchk++; if (log_idx.size() - b !== 7) begin nerr++; $display("FAIL abort_no_idx4 got %0d writes want 7", log_idx.size() - b); end
    endtask

    task automatic test_nack_once();
        int b, d;
        int exp[4] = '{6, 7, 7, 8};
        b = log_idx.size();
        d = done_ids.size();
        nack_idx = 7;
        nack_times = 1;
        send(3, 6, 3);
        wait_done(d + 1, "nack_once");
        nchk++; if (log_idx.size() - b !== 4) begin nerr++; $display("FAIL retry_count got %0d want 4", log_idx.size() - b); end
        if (log_idx.size() - b == 4)
            for (int i = 0; i < 4; i++) begin
                nchk++;
                if (log_idx[b+i] !== exp[i]) begin nerr++; $display("FAIL retry_seq%0d got %0d want %0d", i, log_idx[b+i], exp[i]); end
            end
        nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL retry_err got %b want 0", err); end
        nchk++; if (done_ids.size() > d && done_ids[d] !== 3) begin nerr++; $display("FAIL retry_id got %0d want 3", done_ids[d]); end
        nack_idx = -1;
    endtask

    task automatic test_len0_and_clamp();
        int b, d;
        b = log_idx.size();
        send(1, 5, 0);
        tick();
        nchk++; if ({done, busy} !== 2'b01) begin nerr++; $display("FAIL len0_fetch got done,busy=%b want 01", {done, busy}); end
        tick();
        nchk++; if ({done, busy, done_id} !== 4'b1001) begin nerr++; $display("FAIL len0_done got done,busy,id=%b want 1001", {done, busy, done_id}); end
        repeat (3) tick();
        nchk++; if (log_idx.size() !== b) begin nerr++; $display("FAIL len0_writes got %0d want 0", log_idx.size() - b); end
        b = log_idx.size();
        d = done_ids.size();
        send(2, 62, 5);
        wait_done(d + 1, "clamp");
        repeat (5) tick();
        nchk++; if (log_idx.size() - b !== 2) begin nerr++; $display("FAIL clamp_count got %0d want 2", log_idx.size() - b); end
        if (log_idx.size() - b == 2) begin
            nchk++; if (log_idx[b] !== 62 || log_idx[b+1] !== 63) begin nerr++; $display("FAIL clamp_seq got %0d,%0d want 62,63", log_idx[b], log_idx[b+1]); end
        end
    endtask

    task automatic test_back_to_back();
        int b, d;
        int exp[3] = '{40, 41, 50};
        b = log_idx.size();
        d = done_ids.size();
        send(0, 40, 2);
        repeat (3) tick();
        send(0, 50, 1);
        wait_done(d + 2, "b2b");
        nchk++; if (log_idx.size() - b !== 3) begin nerr++; $display("FAIL b2b_count got %0d want 3", log_idx.size() - b); end
        if (log_idx.size() - b == 3)
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (log_idx[b+i] !== exp[i]) begin nerr++; $display("FAIL b2b_seq%0d got %0d want %0d", i, log_idx[b+i], exp[i]); end
            end
        nchk++; if (done_with_busy !== 0) begin nerr++; $display("FAIL done_overlap got %0d want 0", done_with_busy); end
    endtask

    task automatic test_reset_wait();
        int b, d, t;
        b = log_idx.size();
        d = done_ids.size();
        send(0, 30, 4);
        t = 0;
        while (log_idx.size() == b && t < 50) begin tick(); t++; end
        nchk++; if (log_idx.size() == b) begin nerr++; $display("FAIL rstwait_issue got 0 writes want 1"); end
        tick();
        nchk++; if (busy !== 1'b1 || wrreg_req !== 1'b0) begin nerr++; $display("FAIL rstwait_state got busy,wr=%b want 10", {busy, wrreg_req}); end
        rst = 1'b1;
        #1;
        nchk++; if ({busy, done, wrreg_req} !== 3'b0) begin nerr++; $display("FAIL rstwait_flags got %b want 000", {busy, done, wrreg_req}); end
        nchk++; if ({dev_id, reg_addr, wr_data} !== 32'h0 || tbl_idx !== '0) begin nerr++; $display("FAIL rstwait_bus got %h idx=%0d want 0", {dev_id, reg_addr, wr_data}, tbl_idx); end
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        nchk++; if (done_ids.size() !== d) begin nerr++; $display("FAIL rstwait_done got %0d dones want 0", done_ids.size() - d); end
        nchk++; if (log_idx.size() - b !== 1 || busy !== 1'b0) begin nerr++; $display("FAIL rstwait_resume got writes=%0d busy=%b want 1,0", log_idx.size() - b, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_nack_persist();
        test_nack_once();
        test_len0_and_clamp();
        test_back_to_back();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
